// File: rtl/regfile_wb_sequencer_if.sv
// regfile_wb_sequencer_if
// Groups the write-back request handshake, the register-file write port and
// the decode hazard lookup for regfile_wb_sequencer.
//   slave  : the sequencer side (takes requests, drives the write port)
//   master : the pipeline / register-file side
// Register ID 4'hF means "no register" on every 4-bit field.
interface regfile_wb_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  dstE;
  logic [63:0] valE;
  logic [3:0]  dstM;
  logic [63:0] valM;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [63:0] wr_data;
  logic        done;
  logic [14:0] busy;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic        hazard;

  modport slave (
    input  in_valid, dstE, valE, dstM, valM, srcA, srcB,
    output in_ready, wr_en, wr_addr, wr_data, done, busy, hazard
  );

  modport master (
    output in_valid, dstE, valE, dstM, valM, srcA, srcB,
    input  in_ready, wr_en, wr_addr, wr_data, done, busy, hazard
  );
endinterface

// File: rtl/regfile_wb_sequencer.sv
// regfile_wb_sequencer
// Serialises one Y86-64 write-back request (up to two destinations, E then M)
// onto a single register-file write port and tracks pending destinations so
// decode can detect read-after-write hazards.
// Ports:
//   clk  - system clock, all state updates on posedge
//   rst  - asynchronous active-high reset
//   wb   - request handshake (in_valid/in_ready, dstE/valE, dstM/valM),
//          write port (wr_en/wr_addr/wr_data), done strobe, busy vector,
//          hazard lookup (srcA/srcB -> hazard)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready for a request; write port idle
// WR_E   | presenting the E write (dstE/valE) on the port
// WR_M   | presenting the M write (dstM/valM) on the port
module regfile_wb_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_sequencer_if.slave wb
);

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_WR_E, S_WR_M} state_t;

  state_t      r_state;
  logic [3:0]  r_dste;
  logic [63:0] r_vale;
  logic [3:0]  r_dstm;
  logic [63:0] r_valm;
  logic [14:0] r_busy;
  logic        r_wr_en;
  logic [3:0]  r_wr_addr;
  logic [63:0] r_wr_data;

  logic        w_doe_in;
  logic        w_dom_in;
  logic        w_dom_q;
  logic [15:0] w_busy16;

  // One-hot busy mask for a register ID; ID F falls off the top and sets nothing.
  function automatic logic [14:0] onehot15(input logic [3:0] id);
    return 15'(16'd1 << id);
  endfunction

  // When both destinations match, M wins (popq %rsp), so E is suppressed.
  assign w_doe_in = (wb.dstE != RNONE) && (wb.dstE != wb.dstM);
  assign w_dom_in = (wb.dstM != RNONE);
  assign w_dom_q  = (r_dstm != RNONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dste    <= '0;
      r_vale    <= '0;
      r_dstm    <= '0;
      r_valm    <= '0;
      r_busy    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= RNONE;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (wb.in_valid) begin
            r_dste <= wb.dstE;
            r_vale <= wb.valE;
            r_dstm <= wb.dstM;
            r_valm <= wb.valM;
            r_busy <= r_busy
                    | (w_doe_in ? onehot15(wb.dstE) : 15'd0)
                    | (w_dom_in ? onehot15(wb.dstM) : 15'd0);
            if (w_doe_in) begin
              r_state   <= S_WR_E;
              r_wr_en   <= 1'b1;
              r_wr_addr <= wb.dstE;
              r_wr_data <= wb.valE;
            end else if (w_dom_in) begin
              r_state   <= S_WR_M;
              r_wr_en   <= 1'b1;
              r_wr_addr <= wb.dstM;
              r_wr_data <= wb.valM;
            end
          end
        end
        S_WR_E: begin
          r_busy <= r_busy & ~onehot15(r_dste);
          if (w_dom_q) begin
            r_state   <= S_WR_M;
            r_wr_addr <= r_dstm;
            r_wr_data <= r_valm;
          end else begin
            r_state   <= S_IDLE;
            r_wr_en   <= 1'b0;
            r_wr_addr <= RNONE;
            r_wr_data <= '0;
          end
        end
        S_WR_M: begin
          r_busy    <= r_busy & ~onehot15(r_dstm);
          r_state   <= S_IDLE;
          r_wr_en   <= 1'b0;
          r_wr_addr <= RNONE;
          r_wr_data <= '0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_wr_en   <= 1'b0;
          r_wr_addr <= RNONE;
          r_wr_data <= '0;
        end
      endcase
    end
  end

  // Bit 15 is a permanent zero so a lookup of register F never reads as busy.
  assign w_busy16 = {1'b0, r_busy};

  assign wb.in_ready = (r_state == S_IDLE);
  assign wb.wr_en    = r_wr_en;
  assign wb.wr_addr  = r_wr_addr;
  assign wb.wr_data  = r_wr_data;
  assign wb.busy     = r_busy;

  // A request with no effective write needs both destinations to be F, and
  // completes in its own accept cycle.
  assign wb.done = !rst && (
                     ((r_state == S_WR_E) && !w_dom_q) ||
                     (r_state == S_WR_M) ||
                     ((r_state == S_IDLE) && wb.in_valid &&
                      (wb.dstE == RNONE) && (wb.dstM == RNONE)));

  assign wb.hazard = ((wb.srcA != RNONE) && w_busy16[wb.srcA]) ||
                     ((wb.srcB != RNONE) && w_busy16[wb.srcB]);

endmodule
